deshift_sram_wr_sched: RTL

- Write-port scheduler between the per-channel bit-serial accumulator deshifters and the single shared output SRAM.
- Each channel presents complete 32-bit words with a request line. The block round-robin arbitrates the one write port among the channels.
- It generates each channel's SRAM address from a per-channel start address and offset counter, and reports per-channel completion and global idle.
- It replaces ad-hoc write-port sharing inside the deshifter array and is sequenced by the layer controller through start and idle.

---
 rtl/deshift_sram_wr_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/deshift_sram_wr_sched.sv
// Round-robin scheduler for the shared output-SRAM write port.
// Deshifter channels post 32-bit words; each gets its own address window.
module deshift_sram_wr_sched #(
    parameter int unsigned NUM_CH     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SRAM_DEPTH = 1024,
    localparam int unsigned ADDR_W    = $clog2(SRAM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     shift_start,
    output logic                     shift_idle,
    input  logic [NUM_CH*ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0]        img_size,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     err_over,
    output logic                     sram_en,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]        sram_data
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // One extra bit so the offset can reach img_size+1 at full SRAM depth.
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    off_q  [NUM_CH];
    logic [CNT_W-1:0]    off_d  [NUM_CH];
    logic [ADDR_W-1:0]   base_q [NUM_CH];
    logic [ADDR_W-1:0]   base_d [NUM_CH];
    logic [ADDR_W-1:0]   size_q, size_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic                err_q, err_d;
    logic                idle_q;
    logic                en_q, en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]   eligible_c;
    logic [NUM_CH-1:0]   grant_c;
    logic                gnt_any_c;
    logic [PTR_W-1:0]    win_c;
    int unsigned         idx_c;

    // First eligible channel at or after the round-robin pointer.
    always_comb begin
        eligible_c = (state_q == ST_RUN) ? (ch_req & ~done_q) : '0;
        gnt_any_c  = 1'b0;
        win_c      = '0;
        idx_c      = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx_c = 32'(ptr_q) + k;
            if (idx_c >= NUM_CH) begin
                idx_c = idx_c - NUM_CH;
            end
            if (!gnt_any_c && eligible_c[PTR_W'(idx_c)]) begin
                gnt_any_c = 1'b1;
                win_c     = PTR_W'(idx_c);
            end
        end
        grant_c = gnt_any_c ? (NUM_CH'(1) << win_c) : '0;
    end

    // Next-state, counters and write-pipeline staging.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        off_d   = off_q;
        base_d  = base_q;
        size_d  = size_q;
        done_d  = done_q;
        err_d   = err_q;
        en_d    = gnt_any_c;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (shift_start) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        base_d[i] = start_addr[i*ADDR_W +: ADDR_W];
                        off_d[i]  = '0;
                    end
                    size_d  = img_size;
                    done_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (|(ch_req & done_q)) begin
                    err_d = 1'b1;
                end
                if (gnt_any_c) begin
                    addr_d       = base_q[win_c] + off_q[win_c][ADDR_W-1:0];
                    data_d       = ch_data[32'(win_c)*DATA_W +: DATA_W];
                    off_d[win_c] = off_q[win_c] + CNT_W'(1);
                    if (off_d[win_c] == ({1'b0, size_q} + CNT_W'(1))) begin
                        done_d[win_c] = 1'b1;
                    end
                    ptr_d = (32'(win_c) == NUM_CH - 1) ? '0 : win_c + PTR_W'(1);
                end
                // Leaving on the completing grant lets DRAIN cover the last write.
                if (&done_d) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q  <= '0;
            size_q <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            idle_q <= 1'b1;
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                off_q[i]  <= '0;
                base_q[i] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            size_q <= size_d;
            done_q <= done_d;
            err_q  <= err_d;
            idle_q <= (state_d == ST_IDLE);
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
            off_q  <= off_d;
            base_q <= base_d;
        end
    end

    assign shift_idle = idle_q;
    assign ch_grant   = grant_c;
    assign ch_done    = done_q;
    assign err_over   = err_q;
    assign sram_en    = en_q;
    assign sram_addr  = addr_q;
    assign sram_data  = data_q;

endmodule
